// File: rtl/store_commit_buffer.sv
// In-order store buffer between MEM and the data cache: stores are pushed speculatively,
// committed in order by writeback, dropped on flush if uncommitted, and drained one per handshake.
module store_commit_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid_i,
    input  logic [ADDR_W-1:0]     push_addr_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic [DATA_W/8-1:0]   push_wstrb_i,
    input  logic                  push_uncached_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic                  commit_i,
    input  logic                  flush_i,
    output logic                  wr_req_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [DATA_W-1:0]     wr_data_o,
    output logic [DATA_W/8-1:0]   wr_wstrb_o,
    output logic                  wr_uncached_o,
    input  logic                  wr_ready_i,
    input  logic [ADDR_W-1:0]     ld_addr_i,
    output logic                  ld_hit_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DATA_W / 8;
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [SW-1:0]     wstrb_q [DEPTH];
    logic              unc_q   [DEPTH];

    logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [CW-1:0] cnt_all_q, cnt_all_d, cnt_cmt_q, cnt_cmt_d;
    logic          push_s, commit_s, drain_s, ld_hit_s;

    // Slot idx is live when its distance from head is below the occupancy count.
    function automatic logic in_window(input logic [PW-1:0] idx, input logic [PW-1:0] head,
                                       input logic [CW-1:0] cnt);
        logic [PW-1:0] off;
        off = idx - head;
        return ({1'b0, off} < cnt);
    endfunction

    assign full_o        = (cnt_all_q == C_DEPTH);
    assign empty_o       = (cnt_all_q == {CW{1'b0}});
    assign wr_req_o      = (cnt_cmt_q != {CW{1'b0}});
    assign wr_addr_o     = addr_q[head_q];
    assign wr_data_o     = data_q[head_q];
    assign wr_wstrb_o    = wstrb_q[head_q];
    assign wr_uncached_o = unc_q[head_q];
    assign ld_hit_o      = ld_hit_s;

    assign push_s   = push_valid_i & ~full_o & ~flush_i;
    assign commit_s = commit_i & (cnt_cmt_q < cnt_all_q);
    assign drain_s  = wr_req_o & wr_ready_i;

    // Next-state pointers/counters; drain, then commit, then flush take effect on one edge.
    always_comb begin
        head_d    = drain_s  ? head_q + P_ONE : head_q;
        cmt_d     = commit_s ? cmt_q + P_ONE  : cmt_q;
        tail_d    = tail_q;
        cnt_all_d = cnt_all_q;
        cnt_cmt_d = cnt_cmt_q;
        case ({commit_s, drain_s})
            2'b10:   cnt_cmt_d = cnt_cmt_q + C_ONE;
            2'b01:   cnt_cmt_d = cnt_cmt_q - C_ONE;
            default: cnt_cmt_d = cnt_cmt_q;
        endcase
        if (flush_i) begin
            tail_d    = cmt_d;
            cnt_all_d = cnt_cmt_d;
        end else begin
            tail_d = push_s ? tail_q + P_ONE : tail_q;
            case ({push_s, drain_s})
                2'b10:   cnt_all_d = cnt_all_q + C_ONE;
                2'b01:   cnt_all_d = cnt_all_q - C_ONE;
                default: cnt_all_d = cnt_all_q;
            endcase
        end
    end

    // Word-granular address match against every live entry, committed or not.
    always_comb begin
        ld_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_window(PW'(i), head_q, cnt_all_q) &&
                ((addr_q[i] >> 2) == (ld_addr_i >> 2))) begin
                ld_hit_s = 1'b1;
            end else begin
                ld_hit_s = ld_hit_s;
            end
        end
    end

    // Pointer and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= {PW{1'b0}};
            cmt_q     <= {PW{1'b0}};
            tail_q    <= {PW{1'b0}};
            cnt_all_q <= {CW{1'b0}};
            cnt_cmt_q <= {CW{1'b0}};
        end else begin
            head_q    <= head_d;
            cmt_q     <= cmt_d;
            tail_q    <= tail_d;
            cnt_all_q <= cnt_all_d;
            cnt_cmt_q <= cnt_cmt_d;
        end
    end

    // Entry payload; contents of free slots are never observed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_q[tail_q]  <= push_addr_i;
            data_q[tail_q]  <= push_data_i;
            wstrb_q[tail_q] <= push_wstrb_i;
            unc_q[tail_q]   <= push_uncached_i;
        end
    end
endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed and randomized bench for store_commit_buffer against a queue-based reference model.
module tb_store_commit_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid_i, push_uncached_i, commit_i, flush_i, wr_ready_i;
    logic [31:0] push_addr_i, push_data_i, ld_addr_i;
    logic [3:0]  push_wstrb_i;
    logic        full_o, empty_o, wr_req_o, wr_uncached_o, ld_hit_o;
    logic [31:0] wr_addr_o, wr_data_o;
    logic [3:0]  wr_wstrb_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        u;
    } ent_t;
    ent_t q[$];
    int   ncmt = 0;

    store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid_i(push_valid_i), .push_addr_i(push_addr_i), .push_data_i(push_data_i),
        .push_wstrb_i(push_wstrb_i), .push_uncached_i(push_uncached_i),
        .full_o(full_o), .empty_o(empty_o), .commit_i(commit_i), .flush_i(flush_i),
        .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .wr_wstrb_o(wr_wstrb_o), .wr_uncached_o(wr_uncached_o), .wr_ready_i(wr_ready_i),
        .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit(input logic [31:0] la);
        foreach (q[i]) if (q[i].a[31:2] == la[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle from a negedge, compare against the model, then advance the model at the edge.
    task automatic cycle(input logic pv, input logic [31:0] pa, input logic [31:0] pd,
                         input logic [3:0] ps, input logic pu, input logic cm,
                         input logic fl, input logic rdy, input logic [31:0] la);
        logic full_pre;
        push_valid_i = pv; push_addr_i = pa; push_data_i = pd; push_wstrb_i = ps;
        push_uncached_i = pu; commit_i = cm; flush_i = fl; wr_ready_i = rdy; ld_addr_i = la;
        #1;
        check("full", full_o, q.size() == DEPTH);
        check("empty", empty_o, q.size() == 0);
        check("wr_req", wr_req_o, ncmt != 0);
        check("ld_hit", ld_hit_o, model_hit(la));
        if (ncmt != 0) begin
            check("wr_addr", wr_addr_o, q[0].a);
            check("wr_data", wr_data_o, q[0].d);
            check("wr_wstrb", wr_wstrb_o, q[0].s);
            check("wr_unc", wr_uncached_o, q[0].u);
        end
        full_pre = (q.size() == DEPTH);
        @(posedge clk);
        if (ncmt != 0 && rdy) begin
            void'(q.pop_front());
            ncmt--;
        end
        if (cm && ncmt < q.size()) ncmt++;
        if (fl) begin
            while (q.size() > ncmt) void'(q.pop_back());
        end else if (pv && !full_pre) begin
            q.push_back('{a: pa, d: pd, s: ps, u: pu});
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic cm, input logic rdy);
        cycle(1'b1, a, a ^ 32'h5A5A_0000, 4'hF, a[4], cm, 1'b0, rdy, 32'h0);
    endtask

    task automatic idle(input logic cm, input logic fl, input logic rdy, input logic [31:0] la);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, cm, fl, rdy, la);
    endtask

    initial begin
        rst_n = 1'b0;
        push_valid_i = 1'b0; push_addr_i = 32'h0; push_data_i = 32'h0; push_wstrb_i = 4'h0;
        push_uncached_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0; wr_ready_i = 1'b0;
        ld_addr_i = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_empty", empty_o, 1'b1);
        check("rst_req", wr_req_o, 1'b0);
        check("rst_full", full_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-drain.
        push(32'h0000_0040, 1'b0, 1'b0);
        push(32'h0000_0044, 1'b1, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_rst_req", wr_req_o, 1'b1);
        ld_addr_i = 32'h0000_0040;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", wr_req_o, 1'b0);
        check("async_rst_empty", empty_o, 1'b1);
        check("async_rst_hit", ld_hit_o, 1'b0);
        q.delete();
        ncmt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h0000_0100, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check("post_rst_addr", wr_addr_o, 32'h0000_0100);
        idle(1'b0, 1'b0, 1'b1, 32'h0);

        // Fill / full.
        for (int i = 0; i < 5; i++) begin
            push(32'h1000 + 32'(i * 4), 1'b0, 1'b0);
            if (i == 3) check("full_after_4", full_o, 1'b1);
        end
        for (int i = 0; i < 8; i++) idle(1'b1, 1'b0, 1'b1, 32'h0);
        check("fill_empty", empty_o, 1'b1);

        // Flush with partial commit.
        push(32'hA000, 1'b0, 1'b0);
        push(32'hB000, 1'b0, 1'b0);
        push(32'hC000, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 32'h0);
        idle(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b1, 32'h0);
        check("flush_empty", empty_o, 1'b1);

        // Backpressure.
        cycle(1'b1, 32'h4000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_data", wr_data_o, 32'hDEAD_BEEF);
            check("bp_strb", wr_wstrb_o, 4'hF);
            idle(1'b0, 1'b0, 1'b0, 32'h0);
        end
        idle(1'b0, 1'b0, 1'b1, 32'h0);
        check("bp_empty", empty_o, 1'b1);

        // Wrap with simultaneous push/commit/drain.
        for (int i = 0; i < 10; i++) push(32'h5000 + 32'(i * 4), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 1'b1, 32'h0);
        check("wrap_empty", empty_o, 1'b1);

        // Load hazard.
        push(32'h2004, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0, 32'h2006);
        check("hit_2006", ld_hit_o, 1'b1);
        idle(1'b0, 1'b0, 1'b0, 32'h2008);
        check("hit_2008", ld_hit_o, 1'b0);
        idle(1'b0, 1'b1, 1'b0, 32'h2006);
        idle(1'b0, 1'b0, 1'b0, 32'h2006);
        check("hit_after_flush", ld_hit_o, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = 32'h3000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            cycle(($urandom_range(0, 99) < 60), a, $urandom, 4'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 99) < 60),
                  32'h3000 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Store-side counterpart to the writeback stage. The MEM stage pushes stores into an in-order FIFO.
- Writeback either commits the oldest store (via its store-buffer commit enable) or discards uncommitted stores on an exception flush.
- Committed stores drain one at a time to the data-cache write port over a valid/ready handshake.
- Also gives load-issue logic a word-address hazard flag.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
ADDR_W, 32, store address width
DATA_W, 32, store data width; byte strobe width is DATA_W/8

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
push_valid_i  input  1  MEM presents a store this cycle
push_addr_i  input  ADDR_W  store physical address
push_data_i  input  DATA_W  store data, already byte-aligned
push_wstrb_i  input  DATA_W/8  byte strobes
push_uncached_i  input  1  store is uncached (SUC)
full_o  output  1  no free entry; MEM must stall
empty_o  output  1  buffer holds no entries
commit_i  input  1  writeback commits oldest uncommitted store (single-cycle pulse)
flush_i  input  1  exception flush; drop all uncommitted entries
wr_req_o  output  1  committed store presented to cache
wr_addr_o  output  ADDR_W  head entry address
wr_data_o  output  DATA_W  head entry data
wr_wstrb_o  output  DATA_W/8  head entry strobes
wr_uncached_o  output  1  head entry uncached flag
wr_ready_i  input  1  cache accepts head store
ld_addr_i  input  ADDR_W  load address being issued
ld_hit_o  output  1  some valid entry matches ld_addr_i word

Behaviour:
- State: entry array (addr, data, wstrb, uncached).
- Pointers: head (drain), cmt (first uncommitted) and tail (next free). Each pointer is log2(DEPTH) bits and wraps modulo DEPTH.
- Counters: cnt_all and cnt_cmt, each log2(DEPTH)+1 bits. Invariant: 0 <= cnt_cmt <= cnt_all <= DEPTH.
- Reset (asynchronous, any time):
  - All pointers and counters go to 0.
  - Entries in flight, committed ones included, are lost.
  - Outputs immediately: wr_req_o=0, full_o=0, empty_o=1, ld_hit_o=0. Entry payload is don't-care.
- Combinational outputs, from registered state only:
  - full_o = (cnt_all==DEPTH)
  - empty_o = (cnt_all==0)
  - wr_req_o = (cnt_cmt!=0)
  - wr_* fields come from entry[head].
- Push: accepted when push_valid_i & ~full_o & ~flush_i.
  - Writes the entry at tail; tail++ and cnt_all++.
  - Push while full is ignored; MEM guarantees this does not happen.
  - No full bypass: a same-cycle drain does not free a slot for a push.
- Commit: effective when commit_i & (cnt_cmt<cnt_all).
  - cmt++ and cnt_cmt++.
  - Commit with no uncommitted entry is ignored.
  - An entry pushed in the same cycle is not committable that cycle.
- Drain: a handshake is wr_req_o & wr_ready_i.
  - head++, cnt_all--, cnt_cmt--.
  - While wr_req_o=1 and wr_ready_i=0, all wr_* outputs stay stable.
  - Latency: a store committed at edge N has wr_req_o=1 in cycle N+1 if it is at head.
- Flush: tail <= cmt (after any same-cycle commit) and cnt_all <= cnt_cmt.
  - Evaluation order within one edge: drain, then commit, then flush. A push in a flush cycle is discarded.
  - Committed entries are never dropped by flush.
  - A drain handshake in the flush cycle completes normally.
- Simultaneous commit and drain: cnt_cmt is unchanged net (+1-1), and the pointers each advance.
- ld_hit_o: 1 iff some entry with index in [head, tail) (committed or not) has addr[ADDR_W-1:2]==ld_addr_i[ADDR_W-1:2].
  - Purely combinational. An entry pushed in the current cycle is not yet visible.
- Uncached entries drain identically. Ordering stays strictly FIFO across cached and uncached entries.

Test Plan:
- Reset mid-drain:
  - Setup: two committed entries, wr_ready_i=0.
  - Stimulus: assert rst_n=0 asynchronously between edges.
  - Required: wr_req_o falls immediately, empty_o=1. After release, a new push of addr 0x100 appears at wr_addr_o once committed.
- Fill/full (DEPTH=4):
  - Stimulus: push 0x1000, 0x1004, 0x1008, 0x100C, then a fifth push 0x1010.
  - Required: full_o=1 after the 4th push; the 5th push is ignored and cnt_all stays 4.
  - Then commit all with wr_ready_i=1. Required: drain order 0x1000..0x100C, then empty_o=1.
- Flush with partial commit:
  - Stimulus: push A, B, C; commit A; then commit B with flush_i in the same cycle.
  - Required: A and B drain; C never appears on wr_*; cnt_all=0 afterwards.
- Backpressure:
  - Stimulus: commit entry data 0xDEADBEEF, wstrb 0xF; hold wr_ready_i=0 for 5 cycles.
  - Required: wr_req_o=1 and the outputs are stable for all 5 cycles; the single handshake then removes the entry.
- Wrap plus simultaneous push/commit/drain:
  - Stimulus: stream 10 stores, pushing, committing and draining in the same cycles.
  - Required: wr_addr_o sequence equals push order across pointer wrap, with no duplicates or losses.
- Load hazard:
  - Stimulus: entry at 0x2004 (uncommitted) present.
  - Required: ld_addr_i=0x2006 gives ld_hit_o=1; 0x2008 gives 0; after flush, 0x2006 gives 0.
